// File: rtl/leb128_pkg.sv
// ---------------------------------------------------------------------------
// leb128_pkg
// Shared constants and types for the LEB128 byte-stream front end and the
// signed/unsigned 32-bit unpackers that sit downstream of it.
//   LEB_MAX_BYTES : longest legal encoding of a 32-bit value, in bytes
//   LEB_CONT_BIT  : bit position of the continuation flag in each byte
//   LEB_LEN_W     : width of an encoding-length field (holds 0..5)
// ---------------------------------------------------------------------------
package leb128_pkg;

    localparam int LEB_MAX_BYTES = 5;
    localparam int LEB_CONT_BIT  = 7;
    localparam int LEB_LEN_W     = 3;

    typedef logic [LEB_LEN_W-1:0]     leb_len_t;
    typedef logic [LEB_MAX_BYTES-1:0] leb_cont_t;

endpackage

// File: rtl/leb128_term_find.sv
// ---------------------------------------------------------------------------
// leb128_term_find
// Combinational priority encoder that locates the first terminating byte
// (continuation bit clear) among the bytes currently available.
// Ports:
//   cont_i   : continuation bits of window bytes 0..4 (bit 0 = oldest byte)
//   avail_i  : number of valid window bytes, 0..5
//   found_o  : a terminator exists within the available bytes
//   len_o    : terminator index + 1, or 5 on an overlong encoding, else 0
//   err_o    : five bytes available and all of them carry the continuation bit
// ---------------------------------------------------------------------------
module leb128_term_find
    import leb128_pkg::*;
(
    input  leb_cont_t cont_i,
    input  leb_len_t  avail_i,
    output logic      found_o,
    output leb_len_t  len_o,
    output logic      err_o
);

    // Lowest available index with a clear continuation bit wins. Bytes past
    // avail_i are ignored even if their bit reads as zero, because the window
    // pads missing bytes with 0x00 and those must not look like terminators.
    // When nothing is found, len_o/err_o report the overlong case only once a
    // full five bytes are present; otherwise everything stays at zero.
    always_comb begin
        found_o = 1'b0;
        err_o   = 1'b0;
        len_o   = '0;
        if (avail_i >= 3'd1 && !cont_i[0]) begin
            found_o = 1'b1;
            len_o   = 3'd1;
        end else if (avail_i >= 3'd2 && !cont_i[1]) begin
            found_o = 1'b1;
            len_o   = 3'd2;
        end else if (avail_i >= 3'd3 && !cont_i[2]) begin
            found_o = 1'b1;
            len_o   = 3'd3;
        end else if (avail_i >= 3'd4 && !cont_i[3]) begin
            found_o = 1'b1;
            len_o   = 3'd4;
        end else if (avail_i >= 3'd5 && !cont_i[4]) begin
            found_o = 1'b1;
            len_o   = 3'd5;
        end else if (avail_i >= 3'd5) begin
            err_o   = 1'b1;
            len_o   = 3'd5;
        end
    end

endmodule

// File: rtl/leb128_stream_window.sv
// ---------------------------------------------------------------------------
// leb128_stream_window
// Buffers an LEB128 byte stream and presents a 5-byte window (w0 = oldest)
// plus the length of the first complete encoding in it.
// Ports:
//   clk, rst_n          : clock and asynchronous active-low reset
//   flush               : synchronous clear, overrides push and pop
//   s_data/s_valid/s_ready : incoming byte stream
//   w0..w4              : window bytes, 0x00 beyond the buffered count
//   w_len/w_err/w_valid : first-encoding length, overlong flag, window valid
//   w_ready             : consumer retires w_len bytes when w_valid is high
// ---------------------------------------------------------------------------
module leb128_stream_window
    import leb128_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] w0,
    output logic [7:0] w1,
    output logic [7:0] w2,
    output logic [7:0] w3,
    output logic [7:0] w4,
    output logic [2:0] w_len,
    output logic       w_err,
    output logic       w_valid,
    input  logic       w_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = DEPTH * 8;

    typedef logic [DEPTH-1:0][7:0] buf_t;

    buf_t          buf_q, buf_d;
    logic [CW-1:0] count_q, count_d;

    leb_cont_t     contBits;
    leb_len_t      availBytes;
    logic          termFound;
    leb_len_t      termLen;
    logic          termErr;

    logic          pushFire;
    logic          popFire;
    logic [CW-1:0] popLen;
    logic [CW-1:0] writeIdx;
    buf_t          bufShifted;
    buf_t          writeMask;
    buf_t          writeByte;

    // Window bytes come straight from the registered buffer, masked to zero
    // past the current occupancy so stale entries never leak downstream.
    assign w0 = (count_q > CW'(0)) ? buf_q[0] : 8'h00;
    assign w1 = (count_q > CW'(1)) ? buf_q[1] : 8'h00;
    assign w2 = (count_q > CW'(2)) ? buf_q[2] : 8'h00;
    assign w3 = (count_q > CW'(3)) ? buf_q[3] : 8'h00;
    assign w4 = (count_q > CW'(4)) ? buf_q[4] : 8'h00;

    assign contBits   = {w4[LEB_CONT_BIT], w3[LEB_CONT_BIT], w2[LEB_CONT_BIT],
                         w1[LEB_CONT_BIT], w0[LEB_CONT_BIT]};
    assign availBytes = (count_q >= CW'(LEB_MAX_BYTES)) ? leb_len_t'(LEB_MAX_BYTES)
                                                        : count_q[LEB_LEN_W-1:0];

    leb128_term_find u_term_find (
        .cont_i  (contBits),
        .avail_i (availBytes),
        .found_o (termFound),
        .len_o   (termLen),
        .err_o   (termErr)
    );

    assign w_valid = termFound | termErr;
    assign w_len   = termLen;
    assign w_err   = termErr;

    // s_ready looks only at occupancy; a pop in the same cycle does not free
    // a slot early, which keeps w_ready off the s_ready timing path.
    assign s_ready  = (count_q < CW'(DEPTH));
    assign pushFire = s_valid & s_ready;
    assign popFire  = w_valid & w_ready;
    assign popLen   = popFire ? CW'(w_len) : '0;
    assign writeIdx = count_q - popLen;

    // Retiring bytes is a right shift of the packed buffer by whole bytes.
    // The incoming byte is then merged at the post-shift tail using a byte
    // mask, so whatever the shift pulled into that slot is overwritten.
    assign bufShifted = buf_q >> {popLen, 3'b000};
    assign writeMask  = DW'(8'hFF) << {writeIdx, 3'b000};
    assign writeByte  = DW'(s_data) << {writeIdx, 3'b000};

    // Next-state for buffer and count. Flush only zeroes the count; the
    // buffer contents are left alone since the window masks them anyway.
    always_comb begin
        buf_d   = buf_q;
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            buf_d = bufShifted;
            if (pushFire) begin
                buf_d = (bufShifted & ~writeMask) | writeByte;
            end
            count_d = count_q - popLen + CW'(pushFire);
        end
    end

    // State registers; reset empties the buffer immediately, without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q   <= '0;
            count_q <= '0;
        end else begin
            buf_q   <= buf_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_leb128_stream_window.sv
// ---------------------------------------------------------------------------
// tb_leb128_stream_window
// Self-checking bench for leb128_stream_window: a table of directed cycles,
// an asynchronous-reset sequence, then randomized traffic compared against a
// queue-based model of the byte stream.
// ---------------------------------------------------------------------------
module tb_leb128_stream_window;

    localparam int DEPTH = 8;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] w0, w1, w2, w3, w4;
    logic [2:0] w_len;
    logic       w_err;
    logic       w_valid;
    logic       w_ready;

    int errors = 0;
    int checks = 0;

    logic [7:0] model[$];

    typedef struct {
        logic        flush;
        logic        sValid;
        logic [7:0]  sData;
        logic        wReady;
        logic        expReady;
        logic        expValid;
        logic [2:0]  expLen;
        logic        expErr;
        logic [39:0] expWin;
    } vec_t;

    vec_t vecs[$];

    leb128_stream_window #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .w0      (w0),
        .w1      (w1),
        .w2      (w2),
        .w3      (w3),
        .w4      (w4),
        .w_len   (w_len),
        .w_err   (w_err),
        .w_valid (w_valid),
        .w_ready (w_ready)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something stalls the main sequence.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    // Record one directed cycle: inputs applied before an edge, expected
    // outputs after it. Window packing is {w4,w3,w2,w1,w0}.
    task automatic addVec(input logic f, input logic sv, input logic [7:0] d, input logic wr,
                          input logic er, input logic ev, input logic [2:0] el, input logic ee,
                          input logic [39:0] ew);
        vec_t v;
        v.flush = f;  v.sValid = sv;  v.sData = d;  v.wReady = wr;
        v.expReady = er;  v.expValid = ev;  v.expLen = el;  v.expErr = ee;  v.expWin = ew;
        vecs.push_back(v);
    endtask

    // Drive all inputs for the coming cycle.
    task automatic applyStimulus(input logic f, input logic sv, input logic [7:0] d, input logic wr);
        flush   = f;
        s_valid = sv;
        s_data  = d;
        w_ready = wr;
    endtask

    // Compare every DUT output against the supplied expectation.
    task automatic checkOutput(input string name, input logic er, input logic ev,
                               input logic [2:0] el, input logic ee, input logic [39:0] ew);
        logic [39:0] win;
        win = {w4, w3, w2, w1, w0};
        checks++;
        if (s_ready !== er) begin
            errors++;
            $display("[TB] FAIL %s s_ready: got %0b want %0b", name, s_ready, er);
        end
        checks++;
        if (w_valid !== ev) begin
            errors++;
            $display("[TB] FAIL %s w_valid: got %0b want %0b", name, w_valid, ev);
        end
        checks++;
        if (w_len !== el) begin
            errors++;
            $display("[TB] FAIL %s w_len: got %0d want %0d", name, w_len, el);
        end
        checks++;
        if (w_err !== ee) begin
            errors++;
            $display("[TB] FAIL %s w_err: got %0b want %0b", name, w_err, ee);
        end
        checks++;
        if (win !== ew) begin
            errors++;
            $display("[TB] FAIL %s window: got %h want %h", name, win, ew);
        end
    endtask

    // Expected outputs derived from the buffered byte list: scan the first
    // min(n,5) bytes for a clear top bit, else flag overlong at five bytes.
    task automatic modelExpect(output logic er, output logic ev, output logic [2:0] el,
                               output logic ee, output logic [39:0] ew);
        int n;
        int avail;
        int t;
        n     = model.size();
        avail = (n < 5) ? n : 5;
        t     = -1;
        ew    = '0;
        for (int i = 0; i < avail; i++) begin
            ew[i*8 +: 8] = model[i];
        end
        for (int i = 0; i < avail; i++) begin
            if (model[i][7] == 1'b0) begin
                t = i;
                break;
            end
        end
        er = (n < DEPTH);
        if (t >= 0) begin
            ev = 1'b1;  el = 3'(t + 1);  ee = 1'b0;
        end else if (n >= 5) begin
            ev = 1'b1;  el = 3'd5;  ee = 1'b1;
        end else begin
            ev = 1'b0;  el = 3'd0;  ee = 1'b0;
        end
    endtask

    // Main sequence: reset, directed table, async reset, random traffic.
    initial begin
        logic        er, ev, ee, f, sv, wr;
        logic [2:0]  el;
        logic [39:0] ew;
        logic [7:0]  d;
        int          wrPct;

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

        // Basic encoding, pop to empty
        addVec(0, 1, 8'hE5, 0,  1, 0, 0, 0, 40'h00000000E5);
        addVec(0, 1, 8'h8E, 0,  1, 0, 0, 0, 40'h0000008EE5);
        addVec(0, 1, 8'h26, 0,  1, 1, 3, 0, 40'h0000268EE5);
        addVec(0, 0, 8'h00, 1,  1, 0, 0, 0, 40'h0000000000);
        // Back-to-back single-byte encodings
        addVec(0, 1, 8'h7F, 1,  1, 1, 1, 0, 40'h000000007F);
        addVec(0, 1, 8'h01, 1,  1, 1, 1, 0, 40'h0000000001);
        addVec(0, 1, 8'h40, 1,  1, 1, 1, 0, 40'h0000000040);
        addVec(0, 0, 8'h00, 1,  1, 0, 0, 0, 40'h0000000000);
        // Overlong encoding, then pop of five
        addVec(0, 1, 8'h80, 0,  1, 0, 0, 0, 40'h0000000080);
        addVec(0, 1, 8'h80, 0,  1, 0, 0, 0, 40'h0000008080);
        addVec(0, 1, 8'h80, 0,  1, 0, 0, 0, 40'h0000808080);
        addVec(0, 1, 8'h80, 0,  1, 0, 0, 0, 40'h0080808080);
        addVec(0, 1, 8'h80, 0,  1, 1, 5, 1, 40'h8080808080);
        addVec(0, 0, 8'h00, 1,  1, 0, 0, 0, 40'h0000000000);
        // Flush discards buffer and a same-cycle push
        addVec(0, 1, 8'hC0, 0,  1, 0, 0, 0, 40'h00000000C0);
        addVec(0, 1, 8'hBB, 0,  1, 0, 0, 0, 40'h000000BBC0);
        addVec(0, 1, 8'h78, 0,  1, 1, 3, 0, 40'h000078BBC0);
        addVec(1, 1, 8'h05, 0,  1, 0, 0, 0, 40'h0000000000);
        addVec(0, 0, 8'h00, 0,  1, 0, 0, 0, 40'h0000000000);
        // Fill to DEPTH, refused ninth byte, pop without bypass, then accept
        addVec(0, 1, 8'h81, 0,  1, 0, 0, 0, 40'h0000000081);
        addVec(0, 1, 8'h81, 0,  1, 0, 0, 0, 40'h0000008181);
        addVec(0, 1, 8'h81, 0,  1, 0, 0, 0, 40'h0000818181);
        addVec(0, 1, 8'h81, 0,  1, 0, 0, 0, 40'h0081818181);
        addVec(0, 1, 8'h81, 0,  1, 1, 5, 1, 40'h8181818181);
        addVec(0, 1, 8'h81, 0,  1, 1, 5, 1, 40'h8181818181);
        addVec(0, 1, 8'h81, 0,  1, 1, 5, 1, 40'h8181818181);
        addVec(0, 1, 8'h81, 0,  0, 1, 5, 1, 40'h8181818181);
        addVec(0, 1, 8'h05, 0,  0, 1, 5, 1, 40'h8181818181);
        addVec(0, 1, 8'h05, 1,  1, 0, 0, 0, 40'h0000818181);
        addVec(0, 1, 8'h05, 1,  1, 1, 4, 0, 40'h0005818181);
        addVec(0, 0, 8'h00, 1,  1, 0, 0, 0, 40'h0000000000);

        #12;
        checkOutput("reset_low", 1, 0, 0, 0, 40'h0);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_released", 1, 0, 0, 0, 40'h0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].flush, vecs[i].sValid, vecs[i].sData, vecs[i].wReady);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d", i), vecs[i].expReady, vecs[i].expValid,
                        vecs[i].expLen, vecs[i].expErr, vecs[i].expWin);
        end

        // Asynchronous reset mid-cycle with bytes buffered
        applyStimulus(1'b0, 1'b1, 8'hE5, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1, 8'h8E, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("pre_async_reset", 1, 0, 0, 0, 40'h0000008EE5);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 1, 0, 0, 0, 40'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model.delete();

        // Randomized traffic against the queue model; w_ready bias alternates
        // so the buffer both drains and fills up to DEPTH.
        for (int c = 0; c < 3000; c++) begin
            modelExpect(er, ev, el, ee, ew);
            checkOutput($sformatf("rand%0d", c), er, ev, el, ee, ew);
            wrPct = (((c / 200) % 2) == 1) ? 15 : 70;
            f  = ($urandom_range(0, 99) < 3);
            sv = ($urandom_range(0, 99) < 70);
            d  = 8'($urandom);
            if ($urandom_range(0, 99) < 70) d[7] = 1'b1;
            wr = ($urandom_range(0, 99) < wrPct);
            applyStimulus(f, sv, d, wr);
            @(posedge clk);
            if (f) begin
                model.delete();
            end else begin
                logic pushOk;
                pushOk = sv && (model.size() < DEPTH);
                if (ev && wr) begin
                    for (int k = 0; k < int'(el); k++) void'(model.pop_front());
                end
                if (pushOk) model.push_back(d);
            end
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
